mem_dbus_ctrl: RTL and testbench

MEM-stage data-bus controller. It sits directly downstream of the EX/MEM pipeline register. Each cycle it consumes the registered slot-1 memory operation (op, address, store data, writeback info). It drives a split-handshake SRAM-like data bus, raises a stall request until the access completes, and produces the aligned and extended writeback result for the MEM/WB register. It also flags address-alignment exceptions and drains outstanding accesses on flush.

---
 rtl/mem_dbus_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_dbus_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: one outstanding SRAM-style access, stall until data_ok, aligned/extended writeback.
// Result appears in the data_ok cycle; held in a buffer while stall_i is high. LL/SC link bit enabled by MEM_LLSC_EN.
module mem_dbus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        waddr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [4:0]        waddr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_e;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4, OP_LW = 4'd5;
  localparam logic [3:0] OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8, OP_LL = 4'd9, OP_SC = 4'd10;

  state_e            state_q, state_d;
  logic              data_req_q, data_req_d, data_wr_q, data_wr_d;
  logic [1:0]        data_size_q, data_size_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [DATA_W-1:0] data_wdata_q, data_wdata_d;
  logic [4:0]        hold_waddr_q, hold_waddr_d;
  logic              hold_we_q, hold_we_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;

  logic              is_load, is_store, is_mem, addr_bad, sc_fail, done_now;
  logic [1:0]        op_size;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] st_data, wb_result;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    op_size  = 2'd2;
    case (mem_op_i)
      OP_LB, OP_LBU: begin is_load = 1'b1;  op_size = 2'd0; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  op_size = 2'd1; end
      OP_LW, OP_LL:        is_load = 1'b1;
      OP_SB:         begin is_store = 1'b1; op_size = 2'd0; end
      OP_SH:         begin is_store = 1'b1; op_size = 2'd1; end
      OP_SW, OP_SC:        is_store = 1'b1;
      default: ;
    endcase
  end

  assign is_mem   = is_load | is_store;
  assign addr_bad = (op_size == 2'd1 && mem_addr_i[0]) || (op_size == 2'd2 && mem_addr_i[1:0] != 2'b00);

  assign adel_o     = is_load & addr_bad;
  assign ades_o     = is_store & addr_bad;
  assign badvaddr_o = (adel_o | ades_o) ? mem_addr_i : '0;

`ifdef MEM_LLSC_EN
  logic llbit_q, llbit_d;
  assign sc_fail = (mem_op_i == OP_SC) && !llbit_q;
`else
  assign sc_fail = 1'b0;
`endif

  always_comb begin
    ld_byte = data_rdata[7:0];
    case (mem_addr_i[1:0])
      2'd1:    ld_byte = data_rdata[15:8];
      2'd2:    ld_byte = data_rdata[23:16];
      2'd3:    ld_byte = data_rdata[31:24];
      default: ld_byte = data_rdata[7:0];
    endcase
    ld_half = mem_addr_i[1] ? data_rdata[31:16] : data_rdata[15:0];

    case (mem_op_i)
      OP_SB:   st_data = {4{reg2_i[7:0]}};
      OP_SH:   st_data = {2{reg2_i[15:0]}};
      default: st_data = reg2_i;
    endcase

    case (mem_op_i)
      OP_LB:        wb_result = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      OP_LBU:       wb_result = {{(DATA_W-8){1'b0}}, ld_byte};
      OP_LH:        wb_result = {{(DATA_W-16){ld_half[15]}}, ld_half};
      OP_LHU:       wb_result = {{(DATA_W-16){1'b0}}, ld_half};
      OP_LW, OP_LL: wb_result = data_rdata;
      OP_SC:        wb_result = {{(DATA_W-1){1'b0}}, 1'b1};
      default:      wb_result = wdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    data_req_d   = data_req_q;
    data_wr_d    = data_wr_q;
    data_size_d  = data_size_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    hold_waddr_d = hold_waddr_q;
    hold_we_d    = hold_we_q;
    hold_wdata_d = hold_wdata_q;
`ifdef MEM_LLSC_EN
    llbit_d      = llbit_q;
`endif
    waddr_o    = waddr_i;
    we_o       = we_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    done_now   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          if (addr_bad || flush_i) begin
            we_o = 1'b0;
          end else if (sc_fail) begin
            wdata_o = '0;
          end else begin
            stallreq_o   = 1'b1;
            we_o         = 1'b0;
            state_d      = S_REQ;
            data_req_d   = 1'b1;
            data_wr_d    = is_store;
            data_size_d  = op_size;
            data_addr_d  = mem_addr_i;
            data_wdata_d = st_data;
          end
        end
      end
      S_REQ: begin
        stallreq_o = 1'b1;
        we_o       = 1'b0;
        if (data_addr_ok) begin
          data_req_d = 1'b0;
          if (flush_i)           state_d = data_data_ok ? S_IDLE : S_DRAIN;
          else if (data_data_ok) done_now = 1'b1;
          else                   state_d = S_WAIT;
        end else if (flush_i) begin
          data_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        stallreq_o = 1'b1;
        we_o       = 1'b0;
        if (data_data_ok) begin
          if (flush_i) state_d = S_IDLE;
          else         done_now = 1'b1;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        waddr_o = hold_waddr_q;
        we_o    = hold_we_q & ~flush_i;
        wdata_o = hold_wdata_q;
        if (flush_i || !stall_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // A memory op queued behind the drain waits; it issues from IDLE afterwards.
        if (is_mem) begin
          we_o       = 1'b0;
          stallreq_o = ~addr_bad;
        end
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (done_now) begin
      stallreq_o   = 1'b0;
      we_o         = we_i;
      wdata_o      = wb_result;
      hold_waddr_d = waddr_i;
      hold_we_d    = we_i;
      hold_wdata_d = wb_result;
      state_d      = stall_i ? S_HOLD : S_IDLE;
`ifdef MEM_LLSC_EN
      if (mem_op_i == OP_LL) llbit_d = 1'b1;
      if (mem_op_i == OP_SC) llbit_d = 1'b0;
`endif
    end
`ifdef MEM_LLSC_EN
    if (flush_i) llbit_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= 2'd0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      hold_waddr_q <= 5'd0;
      hold_we_q    <= 1'b0;
      hold_wdata_q <= '0;
`ifdef MEM_LLSC_EN
      llbit_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      data_req_q   <= data_req_d;
      data_wr_q    <= data_wr_d;
      data_size_q  <= data_size_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      hold_waddr_q <= hold_waddr_d;
      hold_we_q    <= hold_we_d;
      hold_wdata_q <= hold_wdata_d;
`ifdef MEM_LLSC_EN
      llbit_q      <= llbit_d;
`endif
    end
  end

  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign data_size  = data_size_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;
endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Bench for mem_dbus_ctrl: directed literal cases, then random ops against a transaction-level model and a memory-backed bus slave.
module tb_mem_dbus_ctrl;
  logic        clk = 1'b0;
  logic        rst, flush_i, stall_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i;
  logic [4:0]  waddr_i;
  logic        we_i;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [4:0]  waddr_o;
  logic        we_o, stallreq_o, adel_o, ades_o;
  logic [31:0] wdata_o, badvaddr_o;

  always #5 clk = ~clk;

  mem_dbus_ctrl dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
  );

  int tests = 0;
  int fails = 0;
  int hs_mon = 0;

  always @(negedge clk) if (data_req === 1'b1 && data_addr_ok === 1'b1) hs_mon++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush_i = 0; stall_i = 0; mem_op_i = 0; mem_addr_i = 0; reg2_i = 0;
    waddr_i = 0; we_i = 0; wdata_i = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  // One access: request in cycle 1 is accepted, data_ok in cycle 2.
  task automatic dir_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] r2, input logic [31:0] rd, input logic we,
                            input logic [1:0] esize, input logic ewr, input logic [31:0] ewd,
                            input logic [31:0] eres);
    mem_op_i = op; mem_addr_i = addr; reg2_i = r2; waddr_i = 5'd7; we_i = we; wdata_i = 32'h0;
    @(negedge clk);
    chk({tag, "_stall_issue"}, stallreq_o, 1);
    tick(); data_addr_ok = 1;
    @(negedge clk);
    chk({tag, "_req"}, data_req, 1);
    chk({tag, "_size"}, data_size, esize);
    chk({tag, "_wr"}, data_wr, ewr);
    chk({tag, "_addr"}, data_addr, addr);
    if (ewr) chk({tag, "_wdata"}, data_wdata, ewd);
    tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = rd;
    @(negedge clk);
    chk({tag, "_stall_done"}, stallreq_o, 0);
    chk({tag, "_we"}, we_o, we);
    if (we) chk({tag, "_result"}, wdata_o, eres);
    tick(); idle_in();
  endtask

  // ---- behavioural model ----
  logic [31:0] mem [16];
  logic        m_llbit;

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] w, input logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (op)
      4'd1:    return b[7] ? (b | 32'hFFFFFF00) : b;
      4'd2:    return b;
      4'd3:    return h[15] ? (h | 32'hFFFF0000) : h;
      4'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_lane(input logic [3:0] op, input logic [31:0] r2);
    if (op == 4'd6) return (r2 & 32'hFF) * 32'h01010101;
    if (op == 4'd7) return (r2 & 32'hFFFF) * 32'h00010001;
    return r2;
  endfunction

  task automatic slave_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] m;
    m = (sz == 2'd0) ? (32'hFF << (8 * a[1:0])) : (sz == 2'd1) ? (32'hFFFF << (16 * a[1])) : 32'hFFFFFFFF;
    mem[a[5:2]] = (mem[a[5:2]] & ~m) | (wd & m);
  endtask

  initial begin
    logic [3:0]  c_op;
    logic [31:0] c_addr, exp_res;
    logic        c_ld, c_st, c_bad, c_scf, c_iss, done, dn, new_op, abort, slv_busy, slv_wr;
    logic [1:0]  c_sz, slv_size;
    logic [31:0] slv_addr, slv_wdata;
    int          hs, age, slv_dly, hs0;

    idle_in();
    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_data_req", data_req, 0);
    chk("rst_data_wr", data_wr, 0);
    chk("rst_data_size", data_size, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_data_wdata", data_wdata, 0);
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_exc", {adel_o, ades_o}, 0);
    chk("rst_badvaddr", badvaddr_o, 0);
    tick(); rst = 0;

    // LW with addr_ok in cycle 1, data_ok in cycle 3
    mem_op_i = 4'd5; mem_addr_i = 32'h1000; waddr_i = 5'd3; we_i = 1; wdata_i = 32'h1234;
    @(negedge clk); chk("lw_c0_stall", stallreq_o, 1); chk("lw_c0_req", data_req, 0); chk("lw_c0_we", we_o, 0);
    tick(); data_addr_ok = 1;
    @(negedge clk); chk("lw_c1_req", data_req, 1); chk("lw_c1_addr", data_addr, 32'h1000); chk("lw_c1_stall", stallreq_o, 1);
    tick(); data_addr_ok = 0;
    @(negedge clk); chk("lw_c2_req", data_req, 0); chk("lw_c2_stall", stallreq_o, 1);
    tick(); data_data_ok = 1; data_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("lw_c3_stall", stallreq_o, 0); chk("lw_c3_wdata", wdata_o, 32'hDEADBEEF);
    chk("lw_c3_we", we_o, 1); chk("lw_c3_waddr", waddr_o, 3);
    tick(); idle_in();

    dir_access("lb", 4'd1, 32'h1003, 0, 32'h80112233, 1, 2'd0, 0, 0, 32'hFFFFFF80);
    dir_access("lbu", 4'd2, 32'h1003, 0, 32'h80112233, 1, 2'd0, 0, 0, 32'h00000080);
    dir_access("lh", 4'd3, 32'h1002, 0, 32'h80112233, 1, 2'd1, 0, 0, 32'hFFFF8011);
    dir_access("lhu", 4'd4, 32'h1000, 0, 32'h80118233, 1, 2'd1, 0, 0, 32'h00008233);
    dir_access("sh", 4'd7, 32'h2002, 32'h0000ABCD, 0, 0, 2'd1, 1, 32'hABCDABCD, 0);
    dir_access("sb", 4'd6, 32'h2001, 32'h123456EF, 0, 0, 2'd0, 1, 32'hEFEFEFEF, 0);

    // misaligned accesses
    mem_op_i = 4'd5; mem_addr_i = 32'h2001; we_i = 1;
    @(negedge clk); chk("mis_lw_adel", adel_o, 1); chk("mis_lw_ades", ades_o, 0);
    chk("mis_lw_bad", badvaddr_o, 32'h2001); chk("mis_lw_stall", stallreq_o, 0); chk("mis_lw_we", we_o, 0);
    tick();
    @(negedge clk); chk("mis_lw_noreq", data_req, 0);
    tick(); mem_op_i = 4'd8; mem_addr_i = 32'h2002; we_i = 0;
    @(negedge clk); chk("mis_sw_ades", ades_o, 1); chk("mis_sw_adel", adel_o, 0); chk("mis_sw_bad", badvaddr_o, 32'h2002);
    tick(); mem_op_i = 4'd3; mem_addr_i = 32'h2003;
    @(negedge clk); chk("mis_lh_adel", adel_o, 1);
    tick();
    @(negedge clk); chk("mis_lh_noreq", data_req, 0);
    tick(); idle_in();

    // stall_i held across data_ok
    hs0 = hs_mon;
    mem_op_i = 4'd5; mem_addr_i = 32'h1004; waddr_i = 5'd4; we_i = 1;
    tick(); data_addr_ok = 1;
    tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFEF00D; stall_i = 1;
    @(negedge clk); chk("hold_c2_stall", stallreq_o, 0); chk("hold_c2_wdata", wdata_o, 32'hCAFEF00D);
    for (int i = 0; i < 2; i++) begin
      tick(); data_data_ok = 0; data_rdata = 32'h0;
      @(negedge clk);
      chk("hold_wdata", wdata_o, 32'hCAFEF00D); chk("hold_we", we_o, 1);
      chk("hold_waddr", waddr_o, 4); chk("hold_stall", stallreq_o, 0); chk("hold_noreq", data_req, 0);
    end
    tick(); stall_i = 0;
    @(negedge clk); chk("hold_exit_wdata", wdata_o, 32'hCAFEF00D); chk("hold_exit_noreq", data_req, 0);
    tick(); idle_in();
    @(negedge clk); chk("hold_one_handshake", hs_mon - hs0, 1);

    // flush while waiting, then drain
    mem_op_i = 4'd5; mem_addr_i = 32'h1008; waddr_i = 5'd8; we_i = 1;
    tick(); data_addr_ok = 1;
    tick(); data_addr_ok = 0; flush_i = 1;
    @(negedge clk); chk("fl_c2_we", we_o, 0);
    tick(); flush_i = 0; mem_op_i = 4'd5; mem_addr_i = 32'h100C; waddr_i = 5'd9;
    @(negedge clk); chk("fl_c3_stall", stallreq_o, 1); chk("fl_c3_noreq", data_req, 0); chk("fl_c3_we", we_o, 0);
    tick(); data_data_ok = 1; data_rdata = 32'h11111111;
    @(negedge clk); chk("fl_c4_we", we_o, 0); chk("fl_c4_stall", stallreq_o, 1); chk("fl_c4_noreq", data_req, 0);
    tick(); data_data_ok = 0;
    @(negedge clk); chk("fl_c5_noreq", data_req, 0); chk("fl_c5_stall", stallreq_o, 1);
    tick(); data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h22222222;
    @(negedge clk); chk("fl_c6_req", data_req, 1); chk("fl_c6_addr", data_addr, 32'h100C);
    chk("fl_c6_stall", stallreq_o, 0); chk("fl_c6_wdata", wdata_o, 32'h22222222); chk("fl_c6_we", we_o, 1);
    tick(); idle_in();

    // LL / SC
    dir_access("ll", 4'd9, 32'h3000, 0, 32'h5A5A5A5A, 1, 2'd2, 0, 0, 32'h5A5A5A5A);
    dir_access("sc_ok", 4'd10, 32'h3000, 32'h77, 0, 1, 2'd2, 1, 32'h77, 32'h1);
    flush_i = 1;
    tick(); flush_i = 0;
`ifdef MEM_LLSC_EN
    mem_op_i = 4'd10; mem_addr_i = 32'h3000; reg2_i = 32'h99; waddr_i = 5'd5; we_i = 1;
    @(negedge clk); chk("sc_fail_stall", stallreq_o, 0); chk("sc_fail_we", we_o, 1); chk("sc_fail_wdata", wdata_o, 0);
    tick();
    @(negedge clk); chk("sc_fail_noreq", data_req, 0);
    tick(); idle_in();
`else
    dir_access("sc_plain", 4'd10, 32'h3000, 32'h99, 0, 1, 2'd2, 1, 32'h99, 32'h1);
`endif

    // random phase
    rst = 1; tick(); tick(); rst = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    m_llbit = 0; slv_busy = 0; slv_dly = 0; slv_wr = 0; slv_size = 0; slv_addr = 0; slv_wdata = 0;
    new_op = 1; abort = 0; done = 0; hs = 0; age = 0;
    c_op = 0; c_addr = 0; c_ld = 0; c_st = 0; c_bad = 0; c_scf = 0; c_iss = 0; c_sz = 0;
    for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
      tick();
      if (new_op) begin
        c_op = 4'($urandom_range(0, 12));
        c_addr = 32'h100 | 32'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 0) c_addr = c_addr & ~32'h3;
        c_ld = (c_op >= 1 && c_op <= 5) || c_op == 9;
        c_st = (c_op >= 6 && c_op <= 8) || c_op == 10;
        c_sz = (c_op == 1 || c_op == 2 || c_op == 6) ? 2'd0 : (c_op == 3 || c_op == 4 || c_op == 7) ? 2'd1 : 2'd2;
        c_bad = (c_ld || c_st) && ((c_sz == 2'd1 && c_addr[0]) || (c_sz == 2'd2 && c_addr[1:0] != 0));
`ifdef MEM_LLSC_EN
        c_scf = (c_op == 10) && !m_llbit;
`else
        c_scf = 0;
`endif
        c_iss = (c_ld || c_st) && !c_bad && !c_scf;
        mem_op_i = c_op; mem_addr_i = c_addr; reg2_i = $urandom; wdata_i = $urandom;
        waddr_i = 5'($urandom_range(0, 31));
        we_i = (c_ld || c_op == 10) ? 1'b1 : c_st ? 1'b0 : 1'($urandom_range(0, 1));
        done = 0; hs = 0; age = 0; new_op = 0;
      end
      stall_i = ($urandom_range(0, 3) == 0);
      data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
      if (!slv_busy && data_req && $urandom_range(0, 1) == 1) begin
        data_addr_ok = 1; slv_busy = 1; slv_dly = $urandom_range(0, 2);
        slv_wr = data_wr; slv_size = data_size; slv_addr = data_addr; slv_wdata = data_wdata;
      end
      if (slv_busy) begin
        if (slv_dly == 0) begin
          data_data_ok = 1; slv_busy = 0;
          if (slv_wr) slave_write(slv_addr, slv_size, slv_wdata);
          else data_rdata = mem[slv_addr[5:2]];
        end else slv_dly--;
      end

      @(negedge clk);
      if (data_req && data_addr_ok) begin
        hs++;
        chk("rnd_bus_addr", data_addr, c_addr);
        chk("rnd_bus_wr", data_wr, c_st);
        chk("rnd_bus_size", data_size, c_sz);
        if (c_st) chk("rnd_bus_wdata", data_wdata, exp_lane(c_op, reg2_i));
      end
      if (!c_iss) chk("rnd_noreq", data_req, 0);
      chk("rnd_adel", adel_o, c_ld && c_bad);
      chk("rnd_ades", ades_o, c_st && c_bad);
      chk("rnd_badvaddr", badvaddr_o, c_bad ? c_addr : 32'h0);
      if (c_iss) begin
        dn = done || data_data_ok;
        chk("rnd_stall", stallreq_o, !dn);
        if (dn) begin
          exp_res = c_ld ? exp_load(c_op, mem[c_addr[5:2]], c_addr[1:0]) : (c_op == 10) ? 32'h1 : wdata_i;
          chk("rnd_we", we_o, we_i);
          if (we_i) begin
            chk("rnd_result", wdata_o, exp_res);
            chk("rnd_waddr", waddr_o, waddr_i);
          end
        end else chk("rnd_we_bubble", we_o, 0);
        done = dn;
      end else begin
        chk("rnd_stall_none", stallreq_o, 0);
        chk("rnd_we_pass", we_o, c_bad ? 1'b0 : we_i);
        if (!c_bad && we_i) begin
          chk("rnd_pass_wdata", wdata_o, c_scf ? 32'h0 : wdata_i);
          chk("rnd_pass_waddr", waddr_o, waddr_i);
        end
      end
      if ((!c_iss || done) && !stall_i) begin
        chk("rnd_handshakes", hs, c_iss ? 1 : 0);
        if (c_iss && c_op == 9) m_llbit = 1;
        if (c_iss && c_op == 10) m_llbit = 0;
        new_op = 1;
      end
      age++;
      if (age > 60) begin
        tests++; fails++;
        $display("FAIL rnd_timeout: op %0d at 0x%08h still pending after %0d cycles, expected completion", c_op, c_addr, age);
        abort = 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
